// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames go out back-to-back while bytes are queued.
// States: IDLE line high, waiting | START start bit | DATA 8 data bits LSB first | STOP stop bit, done pulse
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_tx_dv,
    input  logic [7:0]                    i_tx_byte,
    output logic                          o_tx_ready,
    output logic                          o_tx_serial,
    output logic                          o_tx_active,
    output logic                          o_tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TC_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TC_PRE  = TW'(CLKS_PER_BIT - 2);
    localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_serial;
    logic            r_active;
    logic            r_done;

    logic            w_push;
    logic            w_pop;
    logic            w_bit_end;
    logic [2:0]      w_idx_nxt;

    // Ready comes only from the registered count, so a pop never frees a slot on the same edge.
    assign o_tx_ready   = (r_count != FULL);
    assign w_push       = i_tx_dv && o_tx_ready;
    assign w_bit_end    = (r_timer == TC_LAST);
    assign w_pop        = (r_count != '0) && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
    assign w_idx_nxt    = r_idx + 3'd1;

    assign o_tx_serial  = r_serial;
    assign o_tx_active  = r_active;
    assign o_tx_done    = r_done;
    assign o_fifo_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_tx_byte;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_serial <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_serial <= 1'b1;
                    r_active <= 1'b0;
                    if (w_pop) begin
                        r_shift  <= r_mem[r_rd_ptr];
                        r_timer  <= '0;
                        r_serial <= 1'b0;
                        r_active <= 1'b1;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_timer  <= '0;
                        r_idx    <= '0;
                        r_serial <= r_shift[0];
                        r_state  <= DATA;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_idx == 3'd7) begin
                            r_serial <= 1'b1;
                            r_state  <= STOP;
                        end else begin
                            r_idx    <= w_idx_nxt;
                            r_serial <= r_shift[w_idx_nxt];
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (w_pop) begin
                            r_shift  <= r_mem[r_rd_ptr];
                            r_serial <= 1'b0;
                            r_state  <= START;
                        end else begin
                            r_active <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                        // Raised one edge early so the pulse covers the final stop-bit cycle.
                        r_done  <= (r_timer == TC_PRE);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_timer  <= '0;
                    r_serial <= 1'b1;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter that serializes bytes onto the FPGA TX pin in 8N1 format: one start bit, 8 data bits LSB first, one stop bit, no parity. A small byte FIFO in front of the shifter accepts bytes from on-chip logic through a valid/ready handshake. Frames go out back-to-back with no idle gap while the FIFO holds data. This block is the transmit counterpart of `Top_UART_Rx`, and its line output is loop-back compatible with that receiver.

## Interface
- `CLKS_PER_BIT`, default 10417: i_clk cycles per bit (100 MHz / 9600 baud); legal range ≥ 2.
- `FIFO_DEPTH`, default 4: byte FIFO depth; must be a power of 2, ≥ 2.
- `i_clk`  in  1  FPGA clock; the single clock domain.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_tx_dv`  in  1  write request; `i_tx_byte` is valid this cycle.
- `i_tx_byte`  in  8  byte to transmit.
- `o_tx_ready`  out  1  FIFO not full; a write is accepted on an edge where `i_tx_dv & o_tx_ready`.
- `o_tx_serial`  out  1  UART line; idles high.
- `o_tx_active`  out  1  high while a frame (start, data or stop bit) is on the line.
- `o_tx_done`  out  1  one-cycle pulse at the end of each stop bit.
- `o_fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO.

## Operation
- **FIFO**
  - Circular buffer with write pointer, read pointer and count.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `o_tx_ready = (count != FIFO_DEPTH)`, driven from registered count.
- **FIFO boundary cases**
  - Write attempted while full: ignored; the byte is dropped and no state changes.
  - Write while full and a pop occurs on the same edge: still refused. Ready is not combinationally relaxed by the pop.
  - Write and pop on the same edge (not full): count unchanged, both pointers advance.
- **FSM states**
  - IDLE: line = 1, `o_tx_active` = 0. If count ≠ 0, pop the head byte into the shift register, clear the bit timer, go to START.
  - START: line = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: line = `shift[index]` for `CLKS_PER_BIT` cycles per bit. The index increments 0..7; after bit 7, go to STOP.
  - STOP: line = 1 for `CLKS_PER_BIT` cycles. On the last cycle, pulse `o_tx_done`. Then:
    - if count ≠ 0, pop the next byte and go directly to START (no idle bit);
    - otherwise go to IDLE.
- **Counter widths**
  - Bit timer: $clog2(CLKS_PER_BIT) bits, counts 0..`CLKS_PER_BIT`-1.
  - Bit index: 3 bits.
- **Output registering**
  - `o_tx_serial`, `o_tx_active` and `o_tx_done` are registered outputs with no combinational path from inputs.
- **Undefined states**
  - Any unused state encoding recovers to IDLE with the line high.

## Timing
- **Reset values** (`i_rst` asserted, asynchronous)
  - `o_tx_serial` = 1, `o_tx_active` = 0, `o_tx_done` = 0.
  - `o_tx_ready` = 1, `o_fifo_count` = 0.
  - FSM = IDLE, all pointers and counters cleared.
- **Reset mid-frame**
  - The line returns high immediately and the frame is truncated.
  - FIFO contents are discarded.
  - No `o_tx_done` pulse.
- **Latency from idle**
  - Byte written at edge E0 (count becomes 1).
  - At E1 the FSM pops it; `o_tx_serial` falls and `o_tx_active` rises after E1.
  - Latency from write to start bit: 1 cycle.
- **Frame length**
  - Exactly 10 × `CLKS_PER_BIT` cycles from start-bit fall to end of stop bit.
  - `o_tx_done` is high during the final stop-bit cycle.
  - If the FIFO is empty, `o_tx_active` falls on the following edge.
- **Back-to-back frames**
  - The next start bit begins on the cycle immediately after the previous stop bit.
  - Throughput is one byte per 10 × `CLKS_PER_BIT` cycles.

## Test plan
- **Single byte.** `CLKS_PER_BIT` = 16; write 0x56 once.
  - Line low 16 cycles, then bits 0,1,1,0,1,0,1,0 each 16 cycles, then high 16 cycles.
  - `o_tx_done` pulses 160 cycles after the start-bit fall; `o_tx_active` is high exactly 160 cycles.
- **Loopback.** Connect `o_tx_serial` to `Top_UART_Rx` `i_Rx_serial` with a matching bit period; send 0x56.
  - `o_RX` = 0x56 after `o_RX_DV`.
  - Repeat with 0x00 and 0xFF; both received correctly.
- **Back-to-back.** Write 0xA5 and 0x3C on consecutive cycles.
  - Two frames in 320 cycles with no high gap between the stop bit and the next start bit.
  - Two `o_tx_done` pulses, 160 cycles apart.
- **FIFO full.** `FIFO_DEPTH` = 4; hold `i_tx_dv` high for 6 consecutive cycles starting from idle with bytes 0x01..0x06.
  - 0x01 is popped at E1.
  - `o_fifo_count` reaches 4 after E4 and `o_tx_ready` drops.
  - 0x06 is refused.
  - Line carries 0x01..0x05 in order.
- **Reset mid-frame.** Assert `i_rst` during data bit 3 of 0xC3 with 2 bytes queued.
  - `o_tx_serial` = 1 and `o_fifo_count` = 0 asynchronously; no `o_tx_done` pulse.
  - After release, the line stays idle high until a new write.
- **Simultaneous write and pop.** Write on the exact STOP-end edge when count = 1.
  - The popped byte starts its frame and the new byte is stored.
  - `o_fifo_count` stays 1 across that edge.
